// File: rtl/decoder_ctrl_pkg.sv
// Shared definitions for the decoder control path: FSM state encoding and
// default code geometry (layers per iteration, iteration cap).
package decoder_ctrl_pkg;

    localparam int DEF_LAYER_NUM = 3;
    localparam int DEF_MAX_ITER  = 10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_RUN       = 3'd2,
        S_DRAIN     = 3'd3,
        S_LAYER_END = 3'd4,
        S_SYND      = 3'd5,
        S_IBUPD     = 3'd6,
        S_TERM      = 3'd7
    } state_e;

endpackage

// File: rtl/layer_iter_ctrl_if.sv
// Signal bundle between the decoding-process scheduler and its neighbours
// (frame source, CNU write-back, syndrome checker, VNU IB-RAM updater).
interface layer_iter_ctrl_if
    import decoder_ctrl_pkg::*;
#(
    parameter int LAYER_W = 2,
    parameter int ITER_W  = 4
);
    // Handshake: ib_update_req is a registered one-cycle pulse; the updater
    // answers with a one-cycle ib_update_ack no earlier than the next cycle,
    // and vnu_update_pend stays high from the req cycle through the ack cycle.
    logic               frame_start;
    logic               frame_ready;
    logic               c2v_mem_we;
    logic               syndrome_valid;
    logic               syndrome_zero;
    logic               ib_update_ack;
    logic               ib_update_req;
    logic               vnu_update_pend;
    logic               layer_finish;
    logic               termination;
    logic [LAYER_W-1:0] layer_idx;
    logic [ITER_W-1:0]  iter_cnt;
    logic               decode_success;
    logic               seq_err;
    state_e             state_dbg;

    modport master (
        output frame_start, c2v_mem_we, syndrome_valid, syndrome_zero, ib_update_ack,
        input  frame_ready, ib_update_req, vnu_update_pend, layer_finish, termination,
        input  layer_idx, iter_cnt, decode_success, seq_err, state_dbg
    );

    modport slave (
        input  frame_start, c2v_mem_we, syndrome_valid, syndrome_zero, ib_update_ack,
        output frame_ready, ib_update_req, vnu_update_pend, layer_finish, termination,
        output layer_idx, iter_cnt, decode_success, seq_err, state_dbg
    );

endinterface

// File: rtl/layer_iter_ctrl_counter.sv
// Layer index and completed-iteration counters. The layer index never wraps
// on its own; the iteration count saturates at MAX_ITER.
module iter_layer_counter #(
    parameter int LAYER_NUM = 3,
    parameter int MAX_ITER  = 10,
    parameter int LAYER_W   = 2,
    parameter int ITER_W    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               layer_inc_i,
    input  logic               layer_wrap_i,
    input  logic               iter_inc_i,
    output logic [LAYER_W-1:0] layer_idx_o,
    output logic [ITER_W-1:0]  iter_cnt_o,
    output logic [ITER_W-1:0]  iter_next_o
);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYER_NUM - 1);
    localparam logic [ITER_W-1:0]  ITER_MAX   = ITER_W'(MAX_ITER);

    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [ITER_W-1:0]  iter_q, iter_d;

    assign iter_next_o = (iter_q == ITER_MAX) ? iter_q : iter_q + ITER_W'(1);

    always_comb begin
        layer_d = layer_q;
        iter_d  = iter_q;
        if (clear_i) begin
            layer_d = '0;
            iter_d  = '0;
        end else begin
            if (layer_wrap_i) begin
                layer_d = '0;
            end else if (layer_inc_i && (layer_q != LAST_LAYER)) begin
                layer_d = layer_q + LAYER_W'(1);
            end
            if (iter_inc_i) begin
                iter_d = iter_next_o;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            layer_q <= '0;
            iter_q  <= '0;
        end else begin
            layer_q <= layer_d;
            iter_q  <= iter_d;
        end
    end

    assign layer_idx_o = layer_q;
    assign iter_cnt_o  = iter_q;

endmodule

// File: rtl/layer_iter_ctrl.sv
// Layer/iteration scheduler feeding the CNU control FSM: turns C2V write-back
// strobes into layer_finish, drives the IB-RAM update handshake and ends decoding.
module layer_iter_ctrl
    import decoder_ctrl_pkg::*;
#(
    parameter int LAYER_NUM  = DEF_LAYER_NUM,
    parameter int MAX_ITER   = DEF_MAX_ITER,
    parameter int WB_LATENCY = 1,
    parameter int LAYER_W    = $clog2(LAYER_NUM),
    parameter int ITER_W     = $clog2(MAX_ITER + 1)
) (
    input logic              read_clk,
    input logic              rst,
    layer_iter_ctrl_if.slave bus
);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYER_NUM - 1);
    localparam logic [ITER_W-1:0]  ITER_MAX   = ITER_W'(MAX_ITER);
    localparam logic [2:0] DRAIN_LAST = (WB_LATENCY == 0) ? 3'd0 : 3'(WB_LATENCY - 1);

    state_e             state_q, state_d;
    logic [2:0]         drain_cnt_q, drain_cnt_d;
    logic               term_q, term_d, ready_q, ready_d, req_q, req_d;
    logic               pend_q, pend_d, lf_q, lf_d, success_q, success_d, err_q, err_d;
    logic               enter_le, cnt_clear, layer_inc, layer_wrap, iter_inc;
    logic [LAYER_W-1:0] layer_idx;
    logic [ITER_W-1:0]  iter_cnt, iter_next;

    iter_layer_counter #(
        .LAYER_NUM(LAYER_NUM), .MAX_ITER(MAX_ITER), .LAYER_W(LAYER_W), .ITER_W(ITER_W)
    ) u_cnt (
        .clk_i(read_clk), .rst_i(rst), .clear_i(cnt_clear), .layer_inc_i(layer_inc),
        .layer_wrap_i(layer_wrap), .iter_inc_i(iter_inc), .layer_idx_o(layer_idx),
        .iter_cnt_o(iter_cnt), .iter_next_o(iter_next)
    );

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        success_d   = success_q;
        err_d       = err_q;
        lf_d        = 1'b0;
        enter_le    = 1'b0;
        cnt_clear   = 1'b0;
        layer_inc   = 1'b0;
        layer_wrap  = 1'b0;
        iter_inc    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.frame_start) begin
                state_d   = S_INIT;
                cnt_clear = 1'b1;
                success_d = 1'b0;
            end
            S_INIT: if (bus.ib_update_ack) state_d = S_RUN;
            S_RUN: if (bus.c2v_mem_we) begin
                drain_cnt_d = '0;
                if (WB_LATENCY == 0) begin
                    state_d  = S_LAYER_END;
                    enter_le = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (drain_cnt_q == DRAIN_LAST) begin
                state_d  = S_LAYER_END;
                enter_le = 1'b1;
            end else begin
                drain_cnt_d = drain_cnt_q + 3'd1;
            end
            // A registered layer_finish marks a non-last layer; otherwise the iteration is done.
            S_LAYER_END: state_d = lf_q ? S_RUN : S_SYND;
            S_SYND: if (bus.syndrome_valid) begin
                iter_inc = 1'b1;
                if (bus.syndrome_zero) begin
                    state_d   = S_TERM;
                    success_d = 1'b1;
                end else if (iter_next == ITER_MAX) begin
                    state_d = S_TERM;
                end else begin
                    state_d    = S_IBUPD;
                    layer_wrap = 1'b1;
                    lf_d       = 1'b1;
                end
            end
            S_IBUPD: if (bus.ib_update_ack) state_d = S_RUN;
            S_TERM:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (enter_le && (layer_idx != LAST_LAYER)) begin
            lf_d      = 1'b1;
            layer_inc = 1'b1;
        end

        if (bus.frame_start && (state_q != S_IDLE)) err_d = 1'b1;
        if (bus.c2v_mem_we && (state_q != S_RUN)) err_d = 1'b1;
        if (bus.ib_update_ack && !(state_q inside {S_INIT, S_IBUPD})) err_d = 1'b1;

        term_d  = (state_d == S_IDLE) || (state_d == S_TERM);
        ready_d = (state_d == S_IDLE);
        pend_d  = (state_d == S_INIT) || (state_d == S_IBUPD);
        req_d   = pend_d && (state_q != state_d);
    end

    always_ff @(posedge read_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            term_q      <= 1'b1;
            ready_q     <= 1'b1;
            req_q       <= 1'b0;
            pend_q      <= 1'b0;
            lf_q        <= 1'b0;
            success_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            term_q      <= term_d;
            ready_q     <= ready_d;
            req_q       <= req_d;
            pend_q      <= pend_d;
            lf_q        <= lf_d;
            success_q   <= success_d;
            err_q       <= err_d;
        end
    end

    assign bus.frame_ready     = ready_q;
    assign bus.termination     = term_q;
    assign bus.ib_update_req   = req_q;
    assign bus.vnu_update_pend = pend_q;
    assign bus.layer_finish    = lf_q;
    assign bus.decode_success  = success_q;
    assign bus.seq_err         = err_q;
    assign bus.layer_idx       = layer_idx;
    assign bus.iter_cnt        = iter_cnt;
    assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_layer_iter_ctrl.sv
// Bench for layer_iter_ctrl: two instances (default geometry with one drain
// cycle; MAX_ITER=2 with no drain) checked every cycle against a phase model.
module tb_layer_iter_ctrl;
    import decoder_ctrl_pkg::*;

    localparam int SIG_FS = 0, SIG_WE = 1, SIG_SV = 2, SIG_SZ = 3, SIG_ACK = 4;
    localparam int DA = 0, DB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_iter_ctrl_if #(.LAYER_W(2), .ITER_W(4)) ifa ();
    layer_iter_ctrl_if #(.LAYER_W(2), .ITER_W(2)) ifb ();

    layer_iter_ctrl #(.LAYER_NUM(3), .MAX_ITER(10), .WB_LATENCY(1)) dut_a (
        .read_clk(clk), .rst(rst), .bus(ifa.slave));
    layer_iter_ctrl #(.LAYER_NUM(3), .MAX_ITER(2), .WB_LATENCY(0)) dut_b (
        .read_clk(clk), .rst(rst), .bus(ifb.slave));

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_ACK, M_RUN, M_WB, M_GAP, M_SYND, M_CLOSE} mphase_e;
    typedef struct {
        mphase_e ph;
        int      wb_left;
        bit      last;
        int      ready, term, req, pend, lf, layer, iter, success, err;
    } model_t;
    typedef struct { int ready, term, req, pend, lf, layer, iter, success, err; } obs_t;

    model_t ma, mb;

    function automatic model_t m_reset();
        model_t m;
        m.ph = M_IDLE; m.wb_left = 0; m.last = 1'b0;
        m.ready = 1; m.term = 1; m.req = 0; m.pend = 0; m.lf = 0;
        m.layer = 0; m.iter = 0; m.success = 0; m.err = 0;
        return m;
    endfunction

    function automatic model_t m_step(input model_t m, input logic fs, input logic we,
                                      input logic sv, input logic sz, input logic ack,
                                      input int max_iter, input int wb, input int nl);
        model_t n;
        int it;
        n = m; n.lf = 0; n.req = 0;
        if (fs && m.ph != M_IDLE) n.err = 1;
        if (we && m.ph != M_RUN) n.err = 1;
        if (ack && m.ph != M_ACK) n.err = 1;
        case (m.ph)
            M_IDLE: if (fs) begin
                n.ph = M_ACK; n.layer = 0; n.iter = 0; n.success = 0;
                n.req = 1; n.pend = 1; n.term = 0; n.ready = 0;
            end
            M_ACK: if (ack) begin n.ph = M_RUN; n.pend = 0; end
            M_RUN: if (we) begin n.ph = M_WB; n.wb_left = wb; end
            M_WB: n.wb_left = m.wb_left - 1;
            M_GAP: n.ph = m.last ? M_SYND : M_RUN;
            M_SYND: if (sv) begin
                it = (m.iter + 1 > max_iter) ? max_iter : m.iter + 1;
                n.iter = it;
                if (sz) begin n.success = 1; n.ph = M_CLOSE; n.term = 1; end
                else if (it == max_iter) begin n.ph = M_CLOSE; n.term = 1; end
                else begin n.lf = 1; n.pend = 1; n.req = 1; n.layer = 0; n.ph = M_ACK; end
            end
            M_CLOSE: begin n.ph = M_IDLE; n.ready = 1; end
            default: n.ph = M_IDLE;
        endcase
        if (n.ph == M_WB && n.wb_left == 0) begin
            if (n.layer < nl - 1) begin n.lf = 1; n.layer = n.layer + 1; n.last = 0; end
            else n.last = 1;
            n.ph = M_GAP;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ma <= m_reset();
            mb <= m_reset();
        end else begin
            ma <= m_step(ma, ifa.frame_start, ifa.c2v_mem_we, ifa.syndrome_valid,
                         ifa.syndrome_zero, ifa.ib_update_ack, 10, 1, 3);
            mb <= m_step(mb, ifb.frame_start, ifb.c2v_mem_we, ifb.syndrome_valid,
                         ifb.syndrome_zero, ifb.ib_update_ack, 2, 0, 3);
        end
    end

    function automatic obs_t m_obs(input model_t m);
        obs_t o;
        o.ready = m.ready; o.term = m.term; o.req = m.req; o.pend = m.pend; o.lf = m.lf;
        o.layer = m.layer; o.iter = m.iter; o.success = m.success; o.err = m.err;
        return o;
    endfunction

    function automatic obs_t get_obs(input int d);
        obs_t o;
        if (d == DA) begin
            o.ready = int'(ifa.frame_ready); o.term = int'(ifa.termination);
            o.req = int'(ifa.ib_update_req); o.pend = int'(ifa.vnu_update_pend);
            o.lf = int'(ifa.layer_finish); o.layer = int'(ifa.layer_idx);
            o.iter = int'(ifa.iter_cnt); o.success = int'(ifa.decode_success);
            o.err = int'(ifa.seq_err);
        end else begin
            o.ready = int'(ifb.frame_ready); o.term = int'(ifb.termination);
            o.req = int'(ifb.ib_update_req); o.pend = int'(ifb.vnu_update_pend);
            o.lf = int'(ifb.layer_finish); o.layer = int'(ifb.layer_idx);
            o.iter = int'(ifb.iter_cnt); o.success = int'(ifb.decode_success);
            o.err = int'(ifb.seq_err);
        end
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic cmp_all(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".frame_ready"}, a.ready, e.ready);
        chk({tag, ".termination"}, a.term, e.term);
        chk({tag, ".ib_update_req"}, a.req, e.req);
        chk({tag, ".vnu_update_pend"}, a.pend, e.pend);
        chk({tag, ".layer_finish"}, a.lf, e.lf);
        chk({tag, ".layer_idx"}, a.layer, e.layer);
        chk({tag, ".iter_cnt"}, a.iter, e.iter);
        chk({tag, ".decode_success"}, a.success, e.success);
        chk({tag, ".seq_err"}, a.err, e.err);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_all("model_a", get_obs(DA), m_obs(ma));
            cmp_all("model_b", get_obs(DB), m_obs(mb));
        end
    end

    task automatic chk_reset(input int d, input string tag);
        obs_t o;
        o = get_obs(d);
        chk({tag, ".term"}, o.term, 1);
        chk({tag, ".ready"}, o.ready, 1);
        chk({tag, ".req"}, o.req, 0);
        chk({tag, ".pend"}, o.pend, 0);
        chk({tag, ".lf"}, o.lf, 0);
        chk({tag, ".layer"}, o.layer, 0);
        chk({tag, ".iter"}, o.iter, 0);
        chk({tag, ".success"}, o.success, 0);
        chk({tag, ".err"}, o.err, 0);
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int d, input int sig, input logic v);
        if (d == DA) begin
            case (sig)
                SIG_FS:  ifa.frame_start = v;
                SIG_WE:  ifa.c2v_mem_we = v;
                SIG_SV:  ifa.syndrome_valid = v;
                SIG_SZ:  ifa.syndrome_zero = v;
                default: ifa.ib_update_ack = v;
            endcase
        end else begin
            case (sig)
                SIG_FS:  ifb.frame_start = v;
                SIG_WE:  ifb.c2v_mem_we = v;
                SIG_SV:  ifb.syndrome_valid = v;
                SIG_SZ:  ifb.syndrome_zero = v;
                default: ifb.ib_update_ack = v;
            endcase
        end
    endtask

    task automatic pulse(input int d, input int sig);
        drive(d, sig, 1'b1);
        tick(1);
        drive(d, sig, 1'b0);
    endtask

    task automatic layers3(input int d);
        for (int l = 0; l < 3; l++) begin
            pulse(d, SIG_WE);
            tick(4);
        end
    endtask

    task automatic synd(input int d, input logic sz);
        drive(d, SIG_SZ, sz);
        pulse(d, SIG_SV);
        drive(d, SIG_SZ, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 5; s++) drive(d, s, 1'b0);
        rst = 1'b1;
        tick(3);
        chk_reset(DA, "reset_a");
        chk_reset(DB, "reset_b");
        chk("reset_a.state", int'(ifa.state_dbg), int'(S_IDLE));
        rst = 1'b0;
        chk_en = 1'b1;
        tick(2);

        // Frame start on A, ack three cycles after the request
        pulse(DA, SIG_FS);
        o = get_obs(DA);
        chk("fs.term_fall", o.term, 0);
        chk("fs.req", o.req, 1);
        chk("fs.pend", o.pend, 1);
        chk("fs.ready", o.ready, 0);
        tick(1);
        o = get_obs(DA);
        chk("fs.req_one_cycle", o.req, 0);
        chk("fs.pend_hold2", o.pend, 1);
        tick(2);
        o = get_obs(DA);
        chk("fs.pend_hold4", o.pend, 1);
        pulse(DA, SIG_ACK);
        o = get_obs(DA);
        chk("fs.pend_drop", o.pend, 0);

        // Layer timing with one drain cycle, first write-back at cycle 100
        while (cyc < 100) tick(1);
        pulse(DA, SIG_WE);
        o = get_obs(DA);
        chk("layer0.lf_not_yet", o.lf, 0);
        tick(1);
        o = get_obs(DA);
        chk("layer0.lf_at_t2", o.lf, 1);
        chk("layer0.idx", o.layer, 1);
        tick(3);
        pulse(DA, SIG_WE);
        tick(1);
        o = get_obs(DA);
        chk("layer1.lf_at_t2", o.lf, 1);
        chk("layer1.idx", o.layer, 2);
        tick(3);
        pulse(DA, SIG_WE);
        tick(4);

        // Iteration continue
        synd(DA, 1'b0);
        o = get_obs(DA);
        chk("iter1.lf", o.lf, 1);
        chk("iter1.pend", o.pend, 1);
        chk("iter1.req", o.req, 1);
        chk("iter1.iter", o.iter, 1);
        chk("iter1.idx", o.layer, 0);
        tick(1);
        pulse(DA, SIG_ACK);
        tick(1);
        layers3(DA);
        synd(DA, 1'b0);
        o = get_obs(DA);
        chk("iter2.iter", o.iter, 2);
        tick(1);
        pulse(DA, SIG_ACK);
        tick(1);

        // Early success at the end of iteration 3
        layers3(DA);
        synd(DA, 1'b1);
        o = get_obs(DA);
        chk("success.term", o.term, 1);
        chk("success.flag", o.success, 1);
        chk("success.iter", o.iter, 3);
        chk("success.no_lf", o.lf, 0);
        chk("success.ready_low", o.ready, 0);
        tick(1);
        o = get_obs(DA);
        chk("success.ready_back", o.ready, 1);
        chk("success.term_idle", o.term, 1);
        tick(3);

        // B: syndrome_valid while idle is harmless
        pulse(DB, SIG_SV);
        o = get_obs(DB);
        chk("b.sv_idle_no_err", o.err, 0);
        pulse(DB, SIG_FS);
        tick(1);
        pulse(DB, SIG_ACK);
        pulse(DB, SIG_FS);
        o = get_obs(DB);
        chk("b.fs_in_run_err", o.err, 1);
        tick(2);
        layers3(DB);
        synd(DB, 1'b0);
        o = get_obs(DB);
        chk("b.iter1.lf", o.lf, 1);
        chk("b.iter1.iter", o.iter, 1);
        tick(1);
        pulse(DB, SIG_ACK);
        tick(1);
        layers3(DB);
        synd(DB, 1'b0);
        o = get_obs(DB);
        chk("b.max.term", o.term, 1);
        chk("b.max.iter", o.iter, 2);
        chk("b.max.success", o.success, 0);
        chk("b.max.no_lf", o.lf, 0);
        tick(2);
        pulse(DB, SIG_ACK);
        o = get_obs(DB);
        chk("b.ack_idle_err", o.err, 1);

        // A: new frame clears counters and success; then protocol error in S_SYND
        pulse(DA, SIG_FS);
        o = get_obs(DA);
        chk("a2.iter_clr", o.iter, 0);
        chk("a2.success_clr", o.success, 0);
        chk("a2.idx_clr", o.layer, 0);
        tick(1);
        pulse(DA, SIG_ACK);
        layers3(DA);
        pulse(DA, SIG_WE);
        o = get_obs(DA);
        chk("a2.we_in_synd_err", o.err, 1);
        chk("a2.state_kept", int'(ifa.state_dbg), int'(S_SYND));
        synd(DA, 1'b0);
        o = get_obs(DA);
        chk("a2.synd_after_err.lf", o.lf, 1);
        chk("a2.err_sticky", o.err, 1);
        tick(1);
        pulse(DA, SIG_ACK);

        // Reset in the drain cycle: no layer_finish, all outputs back to reset values
        pulse(DA, SIG_WE);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_reset(DA, "mid_drain_rst");
        chk("mid_drain_rst.state", int'(ifa.state_dbg), int'(S_IDLE));
        tick(2);
        o = get_obs(DA);
        chk("after_rst.no_lf", o.lf, 0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
